// File: rtl/ttl_74161.sv
// 74161-style synchronous presettable binary counter with asynchronous active-low clear.
// RCO flags terminal count gated by ENT, so stages cascade via RCO -> ENT.
module ttl_74161 #(
    parameter int WIDTH      = 4,
    parameter int DELAY_RISE = 0,
    parameter int DELAY_FALL = 0
) (
    input  logic             Clk,
    input  logic             Clear_bar,
    input  logic             Load_bar,
    input  logic             ENP,
    input  logic             ENT,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             RCO
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             rco_d;

    // Load beats counting; counting needs both enables; otherwise hold.
    always_comb begin
        count_d = count_q;
        if (!Load_bar) begin
            count_d = D;
        end else if (ENP && ENT) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge Clk or negedge Clear_bar) begin
        if (!Clear_bar) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Purely combinational so RCO follows ENT without waiting for a clock.
    assign rco_d = ENT & (&count_q);

    generate
        if (DELAY_RISE == 0 && DELAY_FALL == 0) begin : g_nodly
            assign Q   = count_q;
            assign RCO = rco_d;
        end else begin : g_dly
            assign #(DELAY_RISE, DELAY_FALL) Q   = count_q;
            assign #(DELAY_RISE, DELAY_FALL) RCO = rco_d;
        end
    endgenerate

endmodule

// File: tb/tb_ttl_74161.sv
// Directed bench for ttl_74161: clear, load, count/wrap, enable gating,
// load priority, mid-count clear, and a modelled 4:1 mux driven from Q[1:0].
module tb_ttl_74161;

    logic       clk;
    logic       clear_bar;
    logic       load_bar;
    logic       enp;
    logic       ent;
    logic [3:0] d;
    logic [3:0] q;
    logic       rco;

    int errors = 0;
    int checks = 0;

    ttl_74161 #(
        .WIDTH      (4),
        .DELAY_RISE (5),
        .DELAY_FALL (3)
    ) dut (
        .Clk       (clk),
        .Clear_bar (clear_bar),
        .Load_bar  (load_bar),
        .ENP       (enp),
        .ENT       (ent),
        .D         (d),
        .Q         (q),
        .RCO       (rco)
    );

    // clock / reset block: period 20, rising edges at 10, 30, 50, ...
    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // one rising edge, then settle past the longest output delay
    task automatic step();
        @(posedge clk);
        #8;
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // downstream 4:1 mux model: A=4'b1010 selected by Q[1:0]
    logic [3:0] mux_a;
    logic [3:0] y_pat;
    logic       y;
    assign y = mux_a[q[1:0]];

    initial begin
        mux_a     = 4'b1010;
        y_pat     = 4'b1010;
        clear_bar = 1'b0;
        load_bar  = 1'b0;
        enp       = 1'b0;
        ent       = 1'b0;
        d         = 4'b1010;

        // clear asserted at t=0 with a pending load
        #6;
        check("clear_q", q, 4'b0000);
        check("clear_rco", {3'b0, rco}, 4'b0000);
        step();
        step();
        check("clear_held_q", q, 4'b0000);
        check("clear_held_rco", {3'b0, rco}, 4'b0000);

        // release clear between edges; load 1101
        clear_bar = 1'b1;
        d         = 4'b1101;
        #1;
        check("release_no_change", q, 4'b0000);
        step();
        check("load_1101", q, 4'b1101);

        // count 1101 -> 1110 -> 1111 -> 0000
        load_bar = 1'b1;
        enp      = 1'b1;
        ent      = 1'b1;
        #6;
        check("rco_low_1101", {3'b0, rco}, 4'b0000);
        step();
        check("count_1110", q, 4'b1110);
        step();
        check("count_1111", q, 4'b1111);
        check("rco_at_1111", {3'b0, rco}, 4'b0001);
        step();
        check("wrap_q", q, 4'b0000);
        check("wrap_rco", {3'b0, rco}, 4'b0000);

        // enable gating from 1111
        load_bar = 1'b0;
        d        = 4'b1111;
        step();
        check("load_1111", q, 4'b1111);
        load_bar = 1'b1;
        enp      = 1'b0;
        ent      = 1'b1;
        step();
        step();
        check("enp_low_hold_q", q, 4'b1111);
        check("enp_low_rco", {3'b0, rco}, 4'b0001);
        enp = 1'b1;
        ent = 1'b0;
        #4;
        check("ent_fall_rco", {3'b0, rco}, 4'b0000);
        step();
        check("ent_low_hold_q", q, 4'b1111);
        check("ent_low_rco", {3'b0, rco}, 4'b0000);

        // load priority over enables
        load_bar = 1'b0;
        enp      = 1'b0;
        ent      = 1'b0;
        d        = 4'b0011;
        step();
        check("load_no_en", q, 4'b0011);
        enp = 1'b1;
        ent = 1'b1;
        d   = 4'b1000;
        step();
        check("load_over_count", q, 4'b1000);

        // mid-count asynchronous clear
        d = 4'b0101;
        step();
        check("load_0101", q, 4'b0101);
        load_bar = 1'b1;
        step();
        check("count_0110", q, 4'b0110);
        clear_bar = 1'b0;
        #2;
        clear_bar = 1'b1;
        #4;
        check("async_clear_q", q, 4'b0000);
        step();
        check("after_clear_count", q, 4'b0001);

        // mux integration: from clear, Y follows A[Q[1:0]] and repeats every 4 edges
        clear_bar = 1'b0;
        #4;
        clear_bar = 1'b1;
        check("mux_y0", {3'b0, y}, {3'b0, y_pat[0]});
        for (int i = 1; i <= 8; i++) begin
            step();
            check($sformatf("mux_y_edge%0d", i), {3'b0, y}, {3'b0, y_pat[i % 4]});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
